// File: rtl/guitar_hero_pkg.sv
// rtl/guitar_hero_pkg.sv - shared state encoding and scoring constants for the hit judge
package guitar_hero_pkg;

  // Lane judge states: IDLE waits for a note, ARMED means a note window is open
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } judge_state_e;

  localparam int SCORE_W_DEF = 16;
  localparam int HIT_PTS     = 1;
  localparam int BONUS_PTS   = 2;

  // Points for a hit, decided by the streak held before this hit is counted
  function automatic int hit_points(input logic [7:0] streak, input int mult_streak);
    return (32'(streak) >= mult_streak) ? BONUS_PTS : HIT_PTS;
  endfunction

endpackage

// File: rtl/note_hit_judge_if.sv
// rtl/note_hit_judge_if.sv - lane-side signal bundle between game logic and the hit judge
interface note_hit_judge_if #(
  parameter int SCORE_W = 16
);
  logic               tick;
  logic               run;
  logic               note_at_line;
  logic               button_n;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [7:0]         streak;
  logic               armed;

  // Game side: drives the shift strobe, note bit and raw key, reads the judgement
  modport master (
    output tick, run, note_at_line, button_n,
    input  hit, miss, score, streak, armed
  );

  // Judge side
  modport slave (
    input  tick, run, note_at_line, button_n,
    output hit, miss, score, streak, armed
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - key synchroniser, stable-level debouncer and press-edge pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Two-flop synchroniser; idles released (high) out of reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the stable level for the full run
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_d;
  end

  // Debounce state and registered one-cycle press pulse on the falling stable edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/note_hit_judge.sv
// rtl/note_hit_judge.sv - per-lane HIT/MISS judge with tick-counted window, score and streak
module note_hit_judge
  import guitar_hero_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WINDOW_TICKS    = 2,
  parameter int MULT_STREAK     = 8,
  parameter int SCORE_W         = SCORE_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  note_hit_judge_if.slave   bus
);

  localparam int WIN_W = $clog2(WINDOW_TICKS + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_TICKS);

  judge_state_e       state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         streak_q, streak_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               press;
  logic               new_note;
  logic [SCORE_W:0]   score_sum;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .button_n_i (bus.button_n),
    .press_o    (press)
  );

  assign new_note  = bus.tick & bus.note_at_line;
  // Extra carry bit catches overflow so the score can pin at all-ones
  assign score_sum = {1'b0, score_q}
                   + (SCORE_W + 1)'(hit_points(streak_q, MULT_STREAK));

  // Judge next state: a press always resolves the open note first, a new note re-arms after
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    score_d   = score_q;
    streak_d  = streak_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    if (!bus.run) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press) begin
            miss_d   = 1'b1;
            streak_d = '0;
          end
          if (new_note) begin
            state_d   = ST_ARMED;
            win_cnt_d = WIN_LOAD;
          end
        end
        ST_ARMED: begin
          if (press) begin
            hit_d    = 1'b1;
            streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
            score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (new_note) begin
              win_cnt_d = WIN_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (new_note) begin
            miss_d    = 1'b1;
            streak_d  = '0;
            win_cnt_d = WIN_LOAD;
          end else if (bus.tick) begin
            if (win_cnt_q == WIN_W'(1)) begin
              miss_d   = 1'b1;
              streak_d = '0;
              state_d  = ST_IDLE;
            end else begin
              win_cnt_d = win_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Judge state, counters and registered result pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      score_q   <= '0;
      streak_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      score_q   <= score_d;
      streak_q  <= streak_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.score  = score_q;
  assign bus.streak = streak_q;
  assign bus.armed  = (state_q == ST_ARMED);

endmodule
